// File: rtl/sram_arbiter_pkg.sv
// Shared widths, FSM encoding and port identifiers for the two-client SRAM arbiter.
package sram_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE      = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE   = 2'd2;
    localparam logic [1:0] ST_RD_CAPTURE = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = ST_IDLE,
        WRITE      = ST_WRITE,
        RD_ISSUE   = ST_RD_ISSUE,
        RD_CAPTURE = ST_RD_CAPTURE
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins; on contention the port that was not granted last wins.
module rr_arbiter2
    import sram_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant0,
    output logic grant1,
    output logic winner
);

    always_comb begin
        grant0 = enable & valid0 & (~valid1 | (last_grant == PORT1));
        grant1 = enable & valid1 & (~valid0 | (last_grant == PORT0));
        winner = grant1 ? PORT1 : PORT0;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin controller serialising two clients' read/write requests onto a single-port synchronous SRAM.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  sram_rst,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    state_t                state_reg;
    logic                  last_grant_reg;
    logic                  port_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  sram_rst_reg;
    logic                  cs_reg;
    logic                  oe_reg;
    logic                  we_reg;
    logic                  rsp0_valid_reg;
    logic                  rsp1_valid_reg;
    logic [DATA_WIDTH-1:0] rsp0_rdata_reg;
    logic [DATA_WIDTH-1:0] rsp1_rdata_reg;

    logic                  arb_enable;
    logic                  grant0;
    logic                  grant1;
    logic                  winner;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Requests are only offered once the SRAM is out of its own reset.
    assign arb_enable = (state_reg == IDLE) && !sram_rst_reg;

    rr_arbiter2 u_rr_arbiter2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant0     (grant0),
        .grant1     (grant1),
        .winner     (winner)
    );

    always_comb begin
        accept    = grant0 | grant1;
        sel_we    = (winner == PORT1) ? req1_we    : req0_we;
        sel_addr  = (winner == PORT1) ? req1_addr  : req0_addr;
        sel_wdata = (winner == PORT1) ? req1_wdata : req0_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT1;
            port_reg       <= PORT0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            sram_rst_reg   <= 1'b1;
            cs_reg         <= 1'b0;
            oe_reg         <= 1'b0;
            we_reg         <= 1'b0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp0_rdata_reg <= '0;
            rsp1_rdata_reg <= '0;
        end else begin
            sram_rst_reg   <= 1'b0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg       <= sel_addr;
                        wdata_reg      <= sel_wdata;
                        port_reg       <= winner;
                        last_grant_reg <= winner;
                        cs_reg         <= 1'b1;
                        oe_reg         <= 1'b0;
                        we_reg         <= sel_we;
                        state_reg      <= sel_we ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: begin
                    cs_reg    <= 1'b0;
                    we_reg    <= 1'b0;
                    state_reg <= IDLE;
                    if (port_reg == PORT1) rsp1_valid_reg <= 1'b1;
                    else                   rsp0_valid_reg <= 1'b1;
                end
                RD_ISSUE: begin
                    // SRAM has latched the address; enable its output for the capture cycle.
                    oe_reg    <= 1'b1;
                    state_reg <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    cs_reg    <= 1'b0;
                    oe_reg    <= 1'b0;
                    state_reg <= IDLE;
                    if (port_reg == PORT1) begin
                        rsp1_rdata_reg <= sram_rdata;
                        rsp1_valid_reg <= 1'b1;
                    end else begin
                        rsp0_rdata_reg <= sram_rdata;
                        rsp0_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    cs_reg    <= 1'b0;
                    oe_reg    <= 1'b0;
                    we_reg    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp0_rdata = rsp0_rdata_reg;
    assign rsp1_rdata = rsp1_rdata_reg;
    assign sram_rst   = sram_rst_reg;
    assign sram_cs    = cs_reg;
    assign sram_oe    = oe_reg;
    assign sram_we    = we_reg;
    assign sram_addr  = addr_reg;
    assign sram_wdata = wdata_reg;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin controller for the 128x8 single-port synchronous `sram`.
- Owns every SRAM control pin and its active-high reset.
- Serialises read and write transactions from two clients using valid/ready request handshakes and one-cycle response pulses.
- Sits between CPU/DMA-style clients and the SRAM instance; the SRAM is never driven directly by clients.

Parameters:
ADDR_WIDTH, 7, SRAM address width (128 entries)
DATA_WIDTH, 8, SRAM data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req0_valid  input  1  port 0 request present
req0_we  input  1  port 0: 1 = write, 0 = read
req0_addr  input  ADDR_WIDTH  port 0 address
req0_wdata  input  DATA_WIDTH  port 0 write data
req0_ready  output  1  port 0 request accepted this cycle
rsp0_valid  output  1  one-cycle port 0 completion pulse
rsp0_rdata  output  DATA_WIDTH  port 0 read data, valid with rsp0_valid
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0, for port 1
sram_rst  output  1  SRAM reset, active high
sram_cs  output  1  SRAM chip select
sram_oe  output  1  SRAM output enable
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_WIDTH  SRAM address
sram_wdata  output  DATA_WIDTH  SRAM data_in
sram_rdata  input  DATA_WIDTH  SRAM data_out (tri-stated when not enabled)

Behaviour:
- Reset asserted (reset=0):
  - Takes effect immediately and asynchronously.
  - state=IDLE, last_grant=1, latched address/data/port cleared.
  - sram_cs/oe/we=0, sram_addr=0, sram_wdata=0.
  - rsp*_valid=0, rsp*_rdata=0, req*_ready=0.
  - sram_rst=1.
- Reset release: sram_rst is registered and drops to 0 on the first rising clk after release. Requests are accepted only while sram_rst=0.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_CAPTURE.
- IDLE:
  - Arbitration picks a winner and asserts its req*_ready combinationally. The loser's ready stays 0.
  - On valid&ready, latch addr, wdata, we and port id, update last_grant, then go to WRITE (we=1) or RD_ISSUE (we=0).
- WRITE:
  - Drive sram_cs=1, sram_we=1, sram_oe=0, latched addr and wdata. The SRAM commits at the closing edge.
  - Next state IDLE. The granted port's rsp_valid=1 for the following cycle; rsp_rdata is unchanged.
- RD_ISSUE:
  - Drive sram_cs=1, sram_we=0, sram_oe=0, latched addr. The SRAM loads its buffer at the closing edge.
  - Next state RD_CAPTURE.
- RD_CAPTURE:
  - Drive sram_cs=1, sram_we=0, sram_oe=1. At the closing edge, register sram_rdata into the granted port's rsp_rdata.
  - Next state IDLE. rsp_valid=1 for the following cycle.
- Outside WRITE/RD_ISSUE/RD_CAPTURE: sram_cs=sram_oe=sram_we=0. sram_addr/sram_wdata hold the last latched values.
- Latency, counted from the accepting edge:
  - Write response valid in cycle +2.
  - Read response valid in cycle +3.
- Throughput: ready exists only in IDLE. Back-to-back writes take 2 cycles each, reads 3 cycles each. A response pulse may coincide with the next acceptance.
- Arbitration:
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins, so port 0 wins first after reset. Continuous contention strictly alternates.
- Request inputs are sampled only at the accepting edge. Changes while not ready have no effect. A requester must hold valid and payload stable until ready.
- Address is used modulo 2^ADDR_WIDTH. No wrap logic is needed: 0x7F is the last entry.
- Reset mid-transaction: the transaction is dropped, no rsp_valid is produced, and a write in WRITE state may or may not have committed. The SRAM is cleared anyway via sram_rst.
- rsp_rdata holds its value until the next read completion on that port.

Decomposition:
- Package sram_arbiter_pkg: ADDR_WIDTH/DATA_WIDTH defaults; state encoding localparams ST_IDLE=2'd0, ST_WRITE=2'd1, ST_RD_ISSUE=2'd2, ST_RD_CAPTURE=2'd3; port id constants PORT0=1'b0, PORT1=1'b1.
- Sub-module rr_arbiter2: inputs valid0, valid1, last_grant, enable; outputs grant0, grant1, winner. Purely combinational. The FSM, latches and reset synchroniser for sram_rst stay in sram_arbiter.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> all outputs 0 with sram_rst=1 during reset; sram_rst=0 one edge after release; port 0 read of 0x05 returns rsp0_rdata=0x00 with rsp0_valid at accept+3.
2. Port 0 writes 0xA5 to 0x12, then port 1 reads 0x12 -> rsp0_valid at accept+2; rsp1_rdata=0xA5 at accept+3; sram_oe=1 only in the RD_CAPTURE cycle.
3. Both ports hold valid with writes (p0: 0x00<=0x11, p1: 0x01<=0x22) for 8 cycles -> grants alternate 0,1,0,1; readback gives 0x11 and 0x22.
4. Port 1 writes 0xFF to 0x7F, then reads 0x7F -> 0xFF; address 0x00 still reads 0x00.
5. Assert reset during RD_CAPTURE of a port 0 read -> sram_cs drops the same cycle; no rsp0_valid; after release a new read of 0x12 returns 0x00.
6. Port 0 toggles req0_addr 0x10->0x20 while not ready (port 1 busy), then is accepted with 0x30 -> SRAM access uses only 0x30.
